// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: synchronise, debounce and edge-detect two buttons into exclusive S/R pulses.
// Define SR_REQ_QUEUE_EN to hold one request that arrives while busy instead of dropping it.
module sr_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_WIDTH     = 2,
    parameter int GAP_CYCLES      = 1,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic overrun
);
    typedef enum logic [1:0] {IDLE, SET_PULSE, CLR_PULSE, GAP} state_t;

    state_t state, nxt;
    logic [1:0] sync0, sync1, lvl, lvl_d, req, pend;
    logic [CNT_W-1:0] cnt;
    logic set_req, clr_req, ovr_nxt, s_nxt, r_nxt;

    assign set_req = req[0];
    assign clr_req = req[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync0 <= '0;
            sync1 <= '0;
            lvl_d <= '0;
            req   <= '0;
        end else begin
            sync0 <= {clr_btn, set_btn};
            sync1 <= sync0;
            lvl_d <= lvl;
            req   <= lvl & ~lvl_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic l;
        logic [CNT_W-1:0] c;
        always_ff @(posedge clk) begin
            if (!reset) begin
                c <= '0;
                l <= 1'b0;
            end else if (sync1[i] == l) c <= '0;
            else if (c == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                c <= '0;
                l <= ~l;
            end else c <= c + 1'b1;
        end
        assign lvl[i] = l;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
        end
    end

    // Clear wins over set in IDLE; a pending slot entry counts as a live request.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:                 nxt = (clr_req | pend[1]) ? CLR_PULSE : (set_req | pend[0]) ? SET_PULSE : IDLE;
            SET_PULSE, CLR_PULSE: if (cnt == CNT_W'(PULSE_WIDTH - 1)) nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            default:              if (cnt == CNT_W'(GAP_CYCLES - 1)) nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = state != IDLE;
        s_nxt = nxt == SET_PULSE;
        r_nxt = nxt == CLR_PULSE;
    end

`ifdef SR_REQ_QUEUE_EN
    logic [1:0] pend_nxt;
    always_comb begin
        pend_nxt = busy ? pend : 2'b00;
        ovr_nxt  = 1'b0;
        if (busy && clr_req) begin
            ovr_nxt  = pend[1];
            pend_nxt = 2'b10;
        end else if (busy && set_req) begin
            ovr_nxt  = |pend;
            pend_nxt = |pend ? pend : 2'b01;
        end
    end
    always_ff @(posedge clk) pend <= !reset ? 2'b00 : pend_nxt;
`else
    assign pend    = 2'b00;
    assign ovr_nxt = busy & (set_req | clr_req);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            S        <= s_nxt;
            R        <= r_nxt;
            conflict <= set_req & clr_req;
            overrun  <= ovr_nxt;
        end
    end
endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// tb_sr_cmd_debouncer: directed checks of debounce latency, glitch rejection, conflict, busy handling and reset.
// Runs with or without SR_REQ_QUEUE_EN.
module tb_sr_cmd_debouncer;
    logic clk = 1'b0;
    logic reset, set_btn, clr_btn;
    logic S, R, busy, conflict, overrun;
    int checks = 0;
    int failures = 0;

    sr_cmd_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_WIDTH(2),
        .GAP_CYCLES(1),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .set_btn(set_btn),
        .clr_btn(clr_btn),
        .S(S),
        .R(R),
        .busy(busy),
        .conflict(conflict),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if ({S, R, conflict, overrun} !== 4'b0000) begin
                failures++;
                $display("FAIL settle: S R conflict overrun = %b, want 0000", {S, R, conflict, overrun});
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        set_btn = 1'b1;
        clr_btn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({S, R, busy, conflict, overrun} !== 5'b00000) begin
                failures++;
                $display("FAIL reset_hold cyc %0d: S R busy conflict overrun = %b, want 00000", k, {S, R, busy, conflict, overrun});
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (S !== (i == 8 || i == 9) || R !== 1'b0 || busy !== (i >= 8 && i <= 10)) begin
                failures++;
                $display("FAIL latency cyc %0d: S=%b R=%b busy=%b, want S=%b R=0 busy=%b", i, S, R, busy, (i == 8 || i == 9), (i >= 8 && i <= 10));
            end
        end
        set_btn = 1'b0;
        settle(14);
    endtask

    task automatic test_glitch;
        clr_btn = 1'b1;
        tick();
        tick();
        tick();
        clr_btn = 1'b0;
        for (int i = 4; i <= 16; i++) begin
            tick();
            checks++;
            if ({S, R, busy, conflict, overrun} !== 5'b00000) begin
                failures++;
                $display("FAIL glitch cyc %0d: S R busy conflict overrun = %b, want 00000", i, {S, R, busy, conflict, overrun});
            end
        end
    endtask

    task automatic test_conflict;
        int pulses = 0;
        set_btn = 1'b1;
        clr_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) begin
                set_btn = 1'b0;
                clr_btn = 1'b0;
            end
            if (conflict) pulses++;
            checks++;
            if (S !== 1'b0 || R !== (i == 8 || i == 9) || conflict !== (i == 8) || overrun !== 1'b0) begin
                failures++;
                $display("FAIL conflict cyc %0d: S=%b R=%b conflict=%b overrun=%b, want S=0 R=%b conflict=%b overrun=0", i, S, R, conflict, overrun, (i == 8 || i == 9), (i == 8));
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL conflict_count: got %0d pulses, want 1", pulses);
        end
    endtask

    task automatic test_busy_request;
        logic exp_r, exp_ovr, exp_busy;
        set_btn = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 3) clr_btn = 1'b1;
`ifdef SR_REQ_QUEUE_EN
            exp_r = (i == 12 || i == 13);
            exp_ovr = 1'b0;
            exp_busy = (i >= 8 && i <= 10) || (i >= 12 && i <= 14);
`else
            exp_r = 1'b0;
            exp_ovr = (i == 11);
            exp_busy = (i >= 8 && i <= 10);
`endif
            checks++;
            if (S !== (i == 8 || i == 9) || R !== exp_r || overrun !== exp_ovr || busy !== exp_busy || conflict !== 1'b0) begin
                failures++;
                $display("FAIL busy_req cyc %0d: S=%b R=%b overrun=%b busy=%b conflict=%b, want S=%b R=%b overrun=%b busy=%b conflict=0",
                         i, S, R, overrun, busy, conflict, (i == 8 || i == 9), exp_r, exp_ovr, exp_busy);
            end
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
        settle(12);
    endtask

    task automatic test_reset_mid_pulse;
        set_btn = 1'b1;
        for (int i = 1; i <= 9; i++) tick();
        checks++;
        if (S !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: S=%b busy=%b, want S=1 busy=1", S, busy);
        end
        reset = 1'b0;
        set_btn = 1'b0;
        tick();
        checks++;
        if ({S, R, busy} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset: S R busy = %b, want 000", {S, R, busy});
        end
        reset = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if ({S, R, busy, overrun} !== 4'b0000) begin
                failures++;
                $display("FAIL post_reset cyc %0d: S R busy overrun = %b, want 0000", i, {S, R, busy, overrun});
            end
        end
        set_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (S !== (i == 8 || i == 9)) begin
                failures++;
                $display("FAIL repress cyc %0d: S=%b, want %b", i, S, (i == 8 || i == 9));
            end
        end
        set_btn = 1'b0;
        settle(12);
    endtask

    task automatic test_random;
        int s_run = 0;
        int r_run = 0;
        for (int n = 0; n < 10030; n++) begin
            if (n < 10000) begin
                if ($urandom_range(0, 5) == 0) set_btn = ~set_btn;
                if ($urandom_range(0, 5) == 0) clr_btn = ~clr_btn;
            end else begin
                set_btn = 1'b0;
                clr_btn = 1'b0;
            end
            tick();
            checks++;
            if (S && R) begin
                failures++;
                $display("FAIL exclusive cyc %0d: S=%b R=%b, want not both 1", n, S, R);
            end
            if (S) s_run++;
            else begin
                if (s_run != 0) begin
                    checks++;
                    if (s_run != 2) begin
                        failures++;
                        $display("FAIL s_width cyc %0d: run %0d, want 2", n, s_run);
                    end
                end
                s_run = 0;
            end
            if (R) r_run++;
            else begin
                if (r_run != 0) begin
                    checks++;
                    if (r_run != 2) begin
                        failures++;
                        $display("FAIL r_width cyc %0d: run %0d, want 2", n, r_run);
                    end
                end
                r_run = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_conflict();
        test_busy_request();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
